// File: rtl/kuznechik_apb_if.sv
// -----------------------------------------------------------------------------
// kuznechik_apb_if
//
// APB slave front-end for a Kuznechik block-cipher core. It holds the 256-bit
// key, the 128-bit plaintext block and the 128-bit result. It also issues a
// one-cycle start pulse to the core and raises a level interrupt when a result
// is ready.
//
// Every APB transfer takes exactly three cycles:
//   setup  - psel=1, penable=0
//   access - psel=1, penable=1
//   wait   - pready=1
// Read data, the error flag and the decoded write are captured when the access
// phase ends. The write itself is committed on the edge that ends the wait
// state.
//
// Register map (word index = paddr[6:2]; paddr[1:0] and upper bits ignored):
//   0x00       CTRL   RW  bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN
//   0x04       STATUS RO  bit0 BUSY, bit1 VALID
//   0x10-0x1C  DIN0-3 RW  plaintext, DIN0 = bits [31:0] of the block
//   0x20-0x3C  KEY0-7 RW  key, KEY0 = bits [31:0] of the key
//   0x40-0x4C  DOUT0-3 RO last captured result
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   paddr .. penable    APB requester inputs
//   prdata, pready,     APB completer outputs (all registered)
//   pslverr
//   core_key_o          key register contents, KEY7..KEY0
//   core_data_o         plaintext register contents, DIN3..DIN0
//   core_start_o        one-cycle start pulse to the cipher core
//   core_done_i         one-cycle completion pulse from the core
//   core_result_i       result from the core, valid with core_done_i
//   irq_o               VALID & IRQ_EN, registered
// -----------------------------------------------------------------------------
module kuznechik_apb_if #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int APB_DATA_WIDTH = 32   // only 32 is supported
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr,
   input  logic [APB_DATA_WIDTH-1:0] pwdata,
   input  logic                      pwrite,
   input  logic                      psel,
   input  logic                      penable,
   output logic [APB_DATA_WIDTH-1:0] prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic [255:0]              core_key_o,
   output logic [127:0]              core_data_o,
   output logic                      core_start_o,
   input  logic                      core_done_i,
   input  logic [127:0]              core_result_i,
   output logic                      irq_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} apb_state_t;
   typedef enum logic       {CIDLE, CBUSY}       core_state_t;

   localparam logic [4:0] IDX_CTRL   = 5'd0;
   localparam logic [4:0] IDX_STATUS = 5'd1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   apb_state_t       r_apb_state;
   core_state_t      r_core_state;

   logic [3:0][31:0] r_din;      // r_din[0]  = DIN0
   logic [7:0][31:0] r_key;      // r_key[0]  = KEY0
   logic [3:0][31:0] r_dout;     // r_dout[0] = DOUT0
   logic             r_irq_en;
   logic             r_valid;
   logic             r_start;
   logic             r_irq;

   logic             r_pready;
   logic             r_pslverr;
   logic [31:0]      r_prdata;

   // Write decoded and checked at the end of the access phase,
   // then committed when the wait state ends.
   logic [4:0]       r_wr_idx;
   logic [31:0]      r_wr_data;
   logic             r_wr_en;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [4:0]  w_idx;
   logic        w_busy;
   logic        w_mapped;
   logic        w_ro;
   logic        w_busy_lock;
   logic        w_err;
   logic [31:0] w_rdata;
   logic        w_start_req;
   logic        w_unused_addr;

   assign w_idx  = paddr[6:2];
   assign w_busy = (r_core_state == CBUSY);

   // Only paddr[6:2] selects a register; the remaining address bits alias.
   assign w_unused_addr = ^{paddr[APB_ADDR_WIDTH-1:7], paddr[1:0]};

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, so no
      // path can leave it unassigned and infer a latch.
      w_mapped    = 1'b0;
      w_ro        = 1'b0;
      w_busy_lock = 1'b0;
      w_rdata     = '0;
      if (w_idx == IDX_CTRL) begin
         w_mapped    = 1'b1;
         w_rdata     = {30'd0, r_irq_en, 1'b0};
         // Clearing IRQ_EN while busy is harmless; only a new START is refused.
         w_busy_lock = w_busy & pwdata[0];
      end else if (w_idx == IDX_STATUS) begin
         w_mapped = 1'b1;
         w_ro     = 1'b1;
         w_rdata  = {30'd0, r_valid, w_busy};
      end else if (w_idx[4:2] == 3'b001) begin        // 0x10-0x1C
         w_mapped    = 1'b1;
         w_rdata     = r_din[w_idx[1:0]];
         w_busy_lock = w_busy;
      end else if (w_idx[4:3] == 2'b01) begin         // 0x20-0x3C
         w_mapped    = 1'b1;
         w_rdata     = r_key[w_idx[2:0]];
         w_busy_lock = w_busy;
      end else if (w_idx[4:2] == 3'b100) begin        // 0x40-0x4C
         w_mapped = 1'b1;
         w_ro     = 1'b1;
         w_rdata  = r_dout[w_idx[1:0]];
      end
   end

   // Key and plaintext stay frozen while the core runs because such writes
   // are rejected here. BUSY can only fall between decode and commit, never
   // rise, so an access that is accepted here stays legal until it commits.
   assign w_err = ~w_mapped | (pwrite & (w_ro | w_busy_lock));

   // ---------------------------------------------------------------------------
   // APB handshake FSM and register writes
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the values from before the edge.
      if (rst_i) begin
         r_apb_state <= IDLE;
         r_pready    <= 1'b0;
         r_pslverr   <= 1'b0;
         r_prdata    <= '0;
         r_wr_idx    <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_irq_en    <= 1'b0;
         // NOTE: the register files are reset as well. They drive the core
         // directly, so they must start from a known zero, not from X.
         r_din       <= '0;
         r_key       <= '0;
      end else begin
         case (r_apb_state)
            IDLE: begin
               if (psel && !penable) begin
                  r_apb_state <= ACCESS;
               end
            end
            ACCESS: begin
               if (psel && penable) begin
                  r_apb_state <= WAIT;
                  r_pready    <= 1'b1;
                  r_pslverr   <= w_err;
                  // Reads that fail and all writes return zero.
                  r_prdata    <= (!pwrite && !w_err) ? w_rdata : 32'd0;
                  r_wr_idx    <= w_idx;
                  r_wr_data   <= pwdata;
                  r_wr_en     <= pwrite && !w_err;
               end else if (!psel) begin
                  // The requester abandoned the transfer: nothing happens.
                  r_apb_state <= IDLE;
               end
            end
            WAIT: begin
               r_apb_state <= IDLE;
               r_pready    <= 1'b0;
               r_pslverr   <= 1'b0;
               r_prdata    <= '0;
               r_wr_en     <= 1'b0;
               if (r_wr_en) begin
                  if (r_wr_idx == IDX_CTRL) begin
                     r_irq_en <= r_wr_data[1];
                  end else if (r_wr_idx[4:2] == 3'b001) begin
                     r_din[r_wr_idx[1:0]] <= r_wr_data;
                  end else if (r_wr_idx[4:3] == 2'b01) begin
                     r_key[r_wr_idx[2:0]] <= r_wr_data;
                  end
               end
            end
            default: begin
               r_apb_state <= IDLE;
            end
         endcase
      end
   end

   // An accepted START=1 write commits on the same edge as the other writes.
   assign w_start_req = (r_apb_state == WAIT) && r_wr_en &&
                        (r_wr_idx == IDX_CTRL) && r_wr_data[0];

   // ---------------------------------------------------------------------------
   // Core sequencing FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Reset in CBUSY abandons the operation with no pulse; a done pulse
         // that arrives later is ignored in CIDLE.
         r_core_state <= CIDLE;
         r_start      <= 1'b0;
         r_valid      <= 1'b0;
         r_dout       <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_irq   <= r_valid & r_irq_en;
         case (r_core_state)
            CIDLE: begin
               // A stray core_done_i here is ignored, and DOUT is left unchanged.
               if (w_start_req) begin
                  r_start      <= 1'b1;
                  r_valid      <= 1'b0;
                  r_core_state <= CBUSY;
               end
            end
            CBUSY: begin
               if (core_done_i) begin
                  r_dout       <= core_result_i;
                  r_valid      <= 1'b1;
                  r_core_state <= CIDLE;
               end
            end
            default: begin
               r_core_state <= CIDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign prdata       = r_prdata;
   assign pready       = r_pready;
   assign pslverr      = r_pslverr;
   assign core_key_o   = r_key;
   assign core_data_o  = r_din;
   assign core_start_o = r_start;
   assign irq_o        = r_irq;

endmodule

// File: tb/tb_kuznechik_apb_if.sv
// -----------------------------------------------------------------------------
// tb_kuznechik_apb_if
//
// Directed bench for kuznechik_apb_if. APB transfers are issued by a small
// task. Every expected value is a hand-computed constant. The core side is
// modelled by driving core_done_i/core_result_i directly.
// -----------------------------------------------------------------------------
module tb_kuznechik_apb_if;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [11:0]  paddr;
   logic [31:0]  pwdata;
   logic         pwrite;
   logic         psel;
   logic         penable;
   logic [31:0]  prdata;
   logic         pready;
   logic         pslverr;
   logic [255:0] core_key_o;
   logic [127:0] core_data_o;
   logic         core_start_o;
   logic         core_done_i;
   logic [127:0] core_result_i;
   logic         irq_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start  = 0;   // start pulses seen, one count per high cycle

   localparam logic [127:0] RES1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [127:0] RES2 = 128'h00000004_00000003_00000002_00000001;

   kuznechik_apb_if dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .paddr         (paddr),
      .pwdata        (pwdata),
      .pwrite        (pwrite),
      .psel          (psel),
      .penable       (penable),
      .prdata        (prdata),
      .pready        (pready),
      .pslverr       (pslverr),
      .core_key_o    (core_key_o),
      .core_data_o   (core_data_o),
      .core_start_o  (core_start_o),
      .core_done_i   (core_done_i),
      .core_result_i (core_result_i),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (core_start_o === 1'b1) n_start++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // One APB transfer. cyc is the cycle (1 = setup) on which pready was seen,
   // or 0 if it never came. With done_w set, a core_done_i pulse is driven so
   // that it is sampled on the edge that completes the transfer.
   task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic done_w, input logic [127:0] res,
                      output logic [31:0] rd, output logic err, output int cyc);
      cyc = 0;
      rd  = '0;
      err = 1'b0;
      @(posedge clk_i); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         if (pready) begin
            cyc = k; rd = prdata; err = pslverr;
            break;
         end
         @(posedge clk_i); #1;
         if (k == 1) penable = 1'b1;
         if (k == 2 && done_w) begin
            core_done_i = 1'b1; core_result_i = res;
         end
      end
      @(posedge clk_i); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; core_done_i = 1'b0;
   endtask

   task automatic apb_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                            input logic exp_err);
      logic [31:0] rd;
      logic        err;
      int          cyc;
      apb(1'b1, a, d, 1'b0, '0, rd, err, cyc);
      check({tag, "_cyc"}, cyc, 3);
      check({tag, "_err"}, err, exp_err);
   endtask

   task automatic apb_read(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                           input logic exp_err, input logic done_w = 1'b0,
                           input logic [127:0] res = '0);
      logic [31:0] rd;
      logic        err;
      int          cyc;
      apb(1'b0, a, 32'd0, done_w, res, rd, err, cyc);
      check({tag, "_cyc"},  cyc, 3);
      check({tag, "_err"},  err, exp_err);
      check({tag, "_data"}, rd, exp_d);
   endtask

   task automatic pulse_done(input logic [127:0] res);
      @(posedge clk_i); #1;
      core_done_i = 1'b1; core_result_i = res;
      @(posedge clk_i); #1;
      core_done_i = 1'b0; core_result_i = '0;
   endtask

   initial begin
      rst_i = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; core_done_i = 1'b0; core_result_i = '0;

      // Reset state
      tick(3);
      check("rst_pready",  pready, 1'b0);
      check("rst_pslverr", pslverr, 1'b0);
      check("rst_prdata",  prdata, 32'd0);
      check("rst_start",   core_start_o, 1'b0);
      check("rst_irq",     irq_o, 1'b0);
      check("rst_key",     core_key_o, 256'd0);
      check("rst_data",    core_data_o, 128'd0);
      rst_i = 1'b0;
      apb_read("rst_status", 12'h004, 32'h0, 1'b0);

      // Key / plaintext write and read-back
      for (int i = 0; i < 8; i++)
         apb_write($sformatf("wr_key%0d", i), 12'h020 + 12'(4 * i), 32'h11111111 * (i + 1), 1'b0);
      for (int i = 0; i < 4; i++)
         apb_write($sformatf("wr_din%0d", i), 12'h010 + 12'(4 * i), 32'hA5A5A5A5, 1'b0);
      for (int i = 0; i < 8; i++)
         apb_read($sformatf("rd_key%0d", i), 12'h020 + 12'(4 * i), 32'h11111111 * (i + 1), 1'b0);
      for (int i = 0; i < 4; i++)
         apb_read($sformatf("rd_din%0d", i), 12'h010 + 12'(4 * i), 32'hA5A5A5A5, 1'b0);
      check("key_out", core_key_o, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                    32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      check("data_out", core_data_o, {4{32'hA5A5A5A5}});
      apb_read("addr_lsb_ignored",   12'h023, 32'h11111111, 1'b0);
      apb_read("addr_upper_ignored", 12'hA20, 32'h11111111, 1'b0);

      // Start an operation
      apb_write("start1", 12'h000, 32'h3, 1'b0);
      tick(3);
      check("start1_one_pulse", n_start, 1);
      apb_read("busy_status", 12'h004, 32'h1, 1'b0);
      apb_read("ctrl_rb",     12'h000, 32'h2, 1'b0);
      check("busy_irq", irq_o, 1'b0);

      // Writes that are refused while busy
      apb_write("busy_din0",  12'h010, 32'hFFFFFFFF, 1'b1);
      apb_write("busy_start", 12'h000, 32'h1, 1'b1);
      apb_write("busy_key7",  12'h03C, 32'h0, 1'b1);
      apb_write("busy_irqen", 12'h000, 32'h2, 1'b0);
      apb_read("busy_din0_rb", 12'h010, 32'hA5A5A5A5, 1'b0);
      apb_read("busy_key7_rb", 12'h03C, 32'h88888888, 1'b0);
      apb_read("busy_dout0",   12'h040, 32'h0, 1'b0);
      check("busy_no_restart", n_start, 1);

      // Completion
      pulse_done(RES1);
      tick(2);
      apb_read("done_status", 12'h004, 32'h2, 1'b0);
      apb_read("dout0", 12'h040, 32'hCAFEF00D, 1'b0);
      apb_read("dout1", 12'h044, 32'h89ABCDEF, 1'b0);
      apb_read("dout2", 12'h048, 32'h01234567, 1'b0);
      apb_read("dout3", 12'h04C, 32'hDEADBEEF, 1'b0);
      check("done_irq", irq_o, 1'b1);

      // A done pulse while idle is ignored
      pulse_done(RES2);
      tick(2);
      apb_read("idle_done_dout0",  12'h040, 32'hCAFEF00D, 1'b0);
      apb_read("idle_done_status", 12'h004, 32'h2, 1'b0);

      // Error cases
      apb_read("unmapped_rd50",  12'h050, 32'h0, 1'b1);
      apb_write("unmapped_wr50", 12'h050, 32'h12345678, 1'b1);
      apb_read("unmapped_rd08",  12'h008, 32'h0, 1'b1);
      apb_write("ro_status_wr",  12'h004, 32'hFFFFFFFF, 1'b1);
      apb_read("ro_status_rb",   12'h004, 32'h2, 1'b0);
      apb_write("ro_dout_wr",    12'h040, 32'h0, 1'b1);
      apb_read("ro_dout_rb",     12'h040, 32'hCAFEF00D, 1'b0);

      // psel dropped after setup: no write, no pready
      @(posedge clk_i); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h12345678;
      @(posedge clk_i); #1;
      psel = 1'b0; pwrite = 1'b0;
      @(negedge clk_i);
      check("abort_pready", pready, 1'b0);
      tick(2);
      apb_read("abort_din1", 12'h014, 32'hA5A5A5A5, 1'b0);

      // Interrupt enable gating
      apb_write("irqen_off", 12'h000, 32'h0, 1'b0);
      tick(2);
      check("irq_gated", irq_o, 1'b0);
      apb_write("irqen_on", 12'h000, 32'h2, 1'b0);
      tick(2);
      check("irq_regated", irq_o, 1'b1);

      // Second operation: VALID clears and DOUT keeps the old result
      apb_write("start2", 12'h000, 32'h3, 1'b0);
      tick(2);
      check("start2_pulses", n_start, 2);
      check("start2_irq", irq_o, 1'b0);
      apb_read("start2_status", 12'h004, 32'h1, 1'b0);
      apb_read("stale_dout0",   12'h040, 32'hCAFEF00D, 1'b0);
      // STATUS read completing on the same edge as core_done_i: pre-edge value
      apb_read("status_race", 12'h004, 32'h1, 1'b0, 1'b1, RES2);
      apb_read("after_race_status", 12'h004, 32'h2, 1'b0);
      apb_read("res2_dout0", 12'h040, 32'h00000001, 1'b0);
      apb_read("res2_dout3", 12'h04C, 32'h00000004, 1'b0);
      check("res2_irq", irq_o, 1'b1);

      // Reset while busy aborts; a later done pulse is ignored
      apb_write("start3", 12'h000, 32'h1, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      tick(2);
      check("rst_busy_pulses", n_start, 3);
      pulse_done(RES1);
      tick(2);
      apb_read("rst_busy_status", 12'h004, 32'h0, 1'b0);
      apb_read("rst_busy_dout0",  12'h040, 32'h0, 1'b0);
      apb_read("rst_busy_key0",   12'h020, 32'h0, 1'b0);
      check("rst_busy_irq", irq_o, 1'b0);
      check("rst_busy_keyout", core_key_o, 256'd0);

      // Reset during the wait state drops pready
      @(posedge clk_i); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
      @(posedge clk_i); #1;
      penable = 1'b1;
      @(posedge clk_i); #1;
      check("wait_pready", pready, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0; psel = 1'b0; penable = 1'b0;
      check("rst_wait_pready", pready, 1'b0);
      check("rst_wait_prdata", prdata, 32'd0);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
